// File: rtl/vga_sync_receiver.sv
// VGA sync receiver: recovers pixel coordinates, line/frame totals and a lock
// indication from the HSync/VSync/RGB pins. Two stages: stage 1 samples the
// pins, stage 2 holds counters and outputs (pixel in at t, out at t+2).
module vga_sync_receiver #(
    parameter int H_TOTAL     = 800,
    parameter int V_TOTAL     = 525,
    parameter int H_ACT_START = 144,
    parameter int H_ACT_END   = 783,
    parameter int V_ACT_START = 36,
    parameter int V_ACT_END   = 515,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hsync,
    input  logic        vsync,
    input  logic [3:0]  red,
    input  logic [3:0]  green,
    input  logic [3:0]  blue,
    output logic        pix_valid,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic [11:0] pix_rgb,
    output logic        locked,
    output logic [9:0]  h_total,
    output logic [9:0]  v_total,
    output logic        sync_err
);

    localparam logic [9:0] HT  = 10'(H_TOTAL);
    localparam logic [9:0] VT  = 10'(V_TOTAL);
    localparam logic [9:0] HAS = 10'(H_ACT_START);
    localparam logic [9:0] HAE = 10'(H_ACT_END);
    localparam logic [9:0] VAS = 10'(V_ACT_START);
    localparam logic [9:0] VAE = 10'(V_ACT_END);
    localparam logic [3:0] LF  = 4'(LOCK_FRAMES);
    localparam logic [9:0] CNT_MAX = 10'h3FF;

    typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} state_t;

    state_t      state, state_nxt;
    logic [3:0]  good, good_nxt;
    logic        viol_seen, viol_seen_nxt;

    // stage 1
    logic        hs_s1, vs_s1, hs_prev;
    logic [11:0] rgb_s1;

    // stage 2 counters and bookkeeping
    logic [9:0]  hcnt, vcnt, hcnt_nxt, vcnt_nxt;
    logic        vs_last;     // vsync level seen at the previous hsync edge
    logic        h_full;      // a line start has been seen, next edge measures a whole line
    logic        v_full;      // a frame start has been seen, next one measures a whole frame

    logic        h_edge, f_start, h_err, v_err, h_loss, viol, act_nxt;
    logic [9:0]  h_meas, v_meas;

    // Stage 1: pin sampling and previous-hsync history for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hs_s1   <= 1'b0;
            vs_s1   <= 1'b0;
            hs_prev <= 1'b0;
            rgb_s1  <= '0;
        end else begin
            hs_s1   <= hsync;
            vs_s1   <= vsync;
            hs_prev <= hs_s1;
            rgb_s1  <= {red, green, blue};
        end
    end

    // Counter next values, measurements and violation detection
    always_comb begin
        h_edge   = hs_s1 && !hs_prev;
        f_start  = h_edge && vs_s1 && !vs_last;
        h_meas   = hcnt + 10'd1;
        v_meas   = vcnt + 10'd1;
        hcnt_nxt = h_edge ? 10'd0 : ((hcnt == CNT_MAX) ? CNT_MAX : h_meas);
        vcnt_nxt = vcnt;
        if (h_edge)
            vcnt_nxt = f_start ? 10'd0 : ((vcnt == CNT_MAX) ? CNT_MAX : v_meas);
        h_err    = h_edge && h_full && (h_meas != HT);
        v_err    = f_start && v_full && (v_meas != VT);
        // an edge on the cycle the counter would saturate is a normal line start
        h_loss   = !h_edge && (hcnt == CNT_MAX - 10'd1);
        viol     = h_err || v_err || h_loss;
    end

    // Lock FSM: next state, good-frame counter and violation memory
    always_comb begin
        state_nxt     = state;
        good_nxt      = good;
        viol_seen_nxt = f_start ? 1'b0 : (viol_seen || viol);
        case (state)
            SEARCH: begin
                if (f_start) begin
                    state_nxt = TRACK;
                    good_nxt  = '0;
                end
            end
            TRACK: begin
                if (h_loss) begin
                    state_nxt = SEARCH;
                    good_nxt  = '0;
                end else if (f_start && !viol && !viol_seen) begin
                    good_nxt = good + 4'd1;
                    if (good + 4'd1 == LF) state_nxt = LOCKED;
                end else if (viol) begin
                    good_nxt = '0;
                end
            end
            LOCKED: begin
                if (h_loss) begin
                    state_nxt = SEARCH;
                    good_nxt  = '0;
                end else if (viol) begin
                    state_nxt = TRACK;
                    good_nxt  = '0;
                end
            end
            default: begin
                state_nxt = SEARCH;
                good_nxt  = '0;
            end
        endcase
        act_nxt = (state_nxt == LOCKED) &&
                  (hcnt_nxt >= HAS) && (hcnt_nxt <= HAE) &&
                  (vcnt_nxt >= VAS) && (vcnt_nxt <= VAE);
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= SEARCH;
            good      <= '0;
            viol_seen <= 1'b0;
        end else begin
            state     <= state_nxt;
            good      <= good_nxt;
            viol_seen <= viol_seen_nxt;
        end
    end

    // Stage 2: counters, measurements and pixel outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcnt      <= '0;
            vcnt      <= '0;
            vs_last   <= 1'b0;
            h_full    <= 1'b0;
            v_full    <= 1'b0;
            h_total   <= '0;
            v_total   <= '0;
            sync_err  <= 1'b0;
            locked    <= 1'b0;
            pix_valid <= 1'b0;
            pix_x     <= '0;
            pix_y     <= '0;
            pix_rgb   <= '0;
        end else begin
            hcnt     <= hcnt_nxt;
            vcnt     <= vcnt_nxt;
            sync_err <= viol;
            locked   <= (state_nxt == LOCKED);
            if (h_edge) vs_last <= vs_s1;
            if (h_edge && h_full) h_total <= h_meas;
            if (f_start && v_full) v_total <= v_meas;
            // partial lines/frames after loss are not measured
            if (h_loss) begin
                h_full <= 1'b0;
                v_full <= 1'b0;
            end else begin
                if (h_edge)  h_full <= 1'b1;
                if (f_start) v_full <= 1'b1;
            end
            pix_valid <= act_nxt;
            if (act_nxt) begin
                pix_x   <= hcnt_nxt - HAS;
                pix_y   <= vcnt_nxt - VAS;
                pix_rgb <= rgb_s1;
            end
        end
    end

endmodule

// File: tb/tb_vga_sync_receiver.sv
// Directed bench for vga_sync_receiver using a reduced 40x12 timing so that
// many frames fit in a short run.
module tb_vga_sync_receiver;

    localparam int HT  = 40;
    localparam int VT  = 12;
    localparam int HAS = 8;
    localparam int HAE = 35;
    localparam int VAS = 3;
    localparam int VAE = 10;
    localparam int HSW = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        hsync = 1'b0, vsync = 1'b0;
    logic [3:0]  red = '0, green = '0, blue = '0;
    logic        pix_valid, locked, sync_err;
    logic [9:0]  pix_x, pix_y, h_total, v_total;
    logic [11:0] pix_rgb;

    int vec = 0, miss = 0;
    int cyc = 0, err_cnt = 0, err_step = -1, drop_step = -1, rise_step = -1;
    int valid_cnt = 0, fstart = 0, f_saved = 0, e0 = 0;
    logic [9:0] err_h = '0, err_v = '0;
    logic locked_q = 1'b0;

    vga_sync_receiver #(
        .H_TOTAL(HT), .V_TOTAL(VT), .H_ACT_START(HAS), .H_ACT_END(HAE),
        .V_ACT_START(VAS), .V_ACT_END(VAE), .LOCK_FRAMES(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .hsync(hsync), .vsync(vsync),
        .red(red), .green(green), .blue(blue),
        .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_rgb(pix_rgb),
        .locked(locked), .h_total(h_total), .v_total(v_total), .sync_err(sync_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // one pixel clock: observe registered outputs, then drive the next pin values
    task automatic step(input logic h, input logic v, input logic [11:0] c);
        @(posedge clk); #1;
        cyc++;
        if (sync_err) begin
            err_cnt++; err_step = cyc; err_h = h_total; err_v = v_total;
        end
        if (!locked && locked_q) drop_step = cyc;
        if (locked && !locked_q) rise_step = cyc;
        locked_q = locked;
        if (pix_valid) valid_cnt++;
        hsync = h; vsync = v; {red, green, blue} = c;
    endtask

    // lines first_l..nl-1 of a frame; short_l gets HT-1 clocks; chk enables pixel checks
    task automatic frame(input int nl, input int short_l, input int first_l, input bit chk);
        int len;
        logic [11:0] c;
        fstart = cyc + 1;
        for (int l = first_l; l < nl; l++) begin
            len = (l == short_l) ? HT - 1 : HT;
            for (int h = 0; h < len; h++) begin
                c = (l >= VAS && l <= VAE && h >= HAS && h <= HAE) ? 12'hFFF : 12'h000;
                if (l == VAS && h == HAS) c = 12'hA5C;
                step(h < HSW, l < 2, c);
                if (chk) begin
                    if (l == VAS - 1 && h == HAS + 2) check("above_vld", 32'(pix_valid), 0);
                    if (l == VAS && h == HAS + 1) check("left_vld", 32'(pix_valid), 0);
                    if (l == VAS && h == HAS + 2) begin
                        check("first_vld", 32'(pix_valid), 1);
                        check("first_x", 32'(pix_x), 0);
                        check("first_y", 32'(pix_y), 0);
                        check("first_rgb", 32'(pix_rgb), 32'h0A5C);
                    end
                    if (l == VAS && h == HAE + 2) begin
                        check("last_col_vld", 32'(pix_valid), 1);
                        check("last_col_x", 32'(pix_x), HAE - HAS);
                        check("last_col_rgb", 32'(pix_rgb), 32'h0FFF);
                    end
                    if (l == VAS && h == HAE + 3) begin
                        check("past_col_vld", 32'(pix_valid), 0);
                        check("past_col_hold_x", 32'(pix_x), HAE - HAS);
                    end
                    if (l == VAE && h == HAS + 2) begin
                        check("last_row_vld", 32'(pix_valid), 1);
                        check("last_row_y", 32'(pix_y), VAE - VAS);
                    end
                    if (l == VAE + 1 && h == HAS + 2) begin
                        check("past_row_vld", 32'(pix_valid), 0);
                        check("past_row_hold_y", 32'(pix_y), VAE - VAS);
                    end
                end
            end
        end
    endtask

    initial begin
        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_locked", 32'(locked), 0);
        check("rst_valid", 32'(pix_valid), 0);
        check("rst_err", 32'(sync_err), 0);
        check("rst_htot", 32'(h_total), 0);
        check("rst_vtot", 32'(v_total), 0);
        check("rst_rgb", 32'(pix_rgb), 0);
        rst_n = 1'b1;

        // nominal: lock at start of 3rd frame, pixel boundaries in 4th
        frame(VT, -1, 0, 0);
        frame(VT, -1, 0, 0);
        frame(VT, -1, 0, 0);
        f_saved = fstart;
        frame(VT, -1, 0, 1);
        check("lock_rise_step", 32'(rise_step), 32'(f_saved + 2));
        check("nom_locked", 32'(locked), 1);
        check("nom_htot", 32'(h_total), HT);
        check("nom_vtot", 32'(v_total), VT);
        check("nom_no_err", 32'(err_cnt), 0);

        // one short line while locked
        e0 = err_cnt;
        frame(VT, 4, 0, 0);
        check("short_err_cnt", 32'(err_cnt), 32'(e0 + 1));
        check("short_htot", 32'(err_h), HT - 1);
        check("short_drop_same", 32'(drop_step), 32'(err_step));
        check("short_unlocked", 32'(locked), 0);
        check("short_htot_after", 32'(h_total), HT);
        frame(VT, -1, 0, 0);
        frame(VT, -1, 0, 0);
        check("short_still_unlk", 32'(locked), 0);
        frame(VT, -1, 0, 0);
        check("short_relock", 32'(locked), 1);

        // hsync loss
        e0 = err_cnt;
        for (int i = 0; i < 1100; i++) step(1'b0, 1'b0, 12'h000);
        check("loss_err_cnt", 32'(err_cnt), 32'(e0 + 1));
        check("loss_unlocked", 32'(locked), 0);
        frame(VT, -1, 0, 0);
        frame(VT, -1, 0, 0);
        check("loss_still_unlk", 32'(locked), 0);
        check("loss_htot_kept", 32'(h_total), HT);
        frame(VT, -1, 0, 0);
        check("loss_relock_step", 32'(rise_step), 32'(fstart + 2));
        check("loss_no_more_err", 32'(err_cnt), 32'(e0 + 1));

        // frame one line short
        e0 = err_cnt;
        frame(VT - 1, -1, 0, 0);
        check("sframe_still_lk", 32'(locked), 1);
        frame(VT, -1, 0, 0);
        check("sframe_err_cnt", 32'(err_cnt), 32'(e0 + 1));
        check("sframe_vtot", 32'(err_v), VT - 1);
        check("sframe_drop_same", 32'(drop_step), 32'(err_step));
        check("sframe_unlocked", 32'(locked), 0);
        frame(VT, -1, 0, 0);
        check("sframe_still_unlk", 32'(locked), 0);
        frame(VT, -1, 0, 0);
        check("sframe_relock", 32'(locked), 1);
        check("sframe_vtot_after", 32'(v_total), VT);

        // asynchronous reset mid-line while locked
        frame(5, -1, 0, 0);
        for (int h = 0; h < 20; h++) step(h < HSW, 1'b0, (h >= HAS) ? 12'hFFF : 12'h000);
        #2 rst_n = 1'b0;
        #1;
        check("arst_locked", 32'(locked), 0);
        check("arst_valid", 32'(pix_valid), 0);
        check("arst_htot", 32'(h_total), 0);
        check("arst_vtot", 32'(v_total), 0);
        check("arst_x", 32'(pix_x), 0);
        check("arst_rgb", 32'(pix_rgb), 0);
        step(1'b0, 1'b0, 12'h000);
        step(1'b0, 1'b0, 12'h000);
        rst_n = 1'b1;
        valid_cnt = 0;
        frame(VT, -1, 6, 0);
        frame(VT, -1, 0, 0);
        frame(VT, -1, 0, 0);
        check("arst_no_valid", 32'(valid_cnt), 0);
        check("arst_unlocked", 32'(locked), 0);
        valid_cnt = 0;
        frame(VT, -1, 0, 0);
        check("arst_relock", 32'(locked), 1);
        check("arst_valid_cnt", 32'(valid_cnt), (HAE - HAS + 1) * (VAE - VAS + 1));
        check("arst_no_err", 32'(err_cnt), 32'(e0 + 1));

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
